// File: rtl/trig_decoder_if.sv
// Bundles the trigger decoder's control inputs and decoded outputs.
// The master side drives the line and settings; the slave side is the decoder.
interface trig_decoder_if #(
  parameter int PTN_W = 3,
  parameter int GAP_W = 12,
  parameter int CNT_W = 16
);
  logic             user_ena;
  logic             trig_in;
  logic [GAP_W-1:0] user_min_gap;
  logic [CNT_W-1:0] user_ntrig;
  logic [PTN_W-1:0] ptn_out;
  logic             ptn_valid;
  logic [CNT_W-1:0] trig_cnt;
  logic             gap_err;
  logic [CNT_W-1:0] err_cnt;
  logic             done;
  logic             busy;

  modport master (
    output user_ena, trig_in, user_min_gap, user_ntrig,
    input  ptn_out, ptn_valid, trig_cnt, gap_err, err_cnt, done, busy
  );

  modport slave (
    input  user_ena, trig_in, user_min_gap, user_ntrig,
    output ptn_out, ptn_valid, trig_cnt, gap_err, err_cnt, done, busy
  );
endinterface

// File: rtl/trig_decoder.sv
// Serial trigger frame decoder: header '1' + PTN_W pattern bits (MSB first),
// with gap checking, saturating frame/error counters and a done level.
module trig_decoder #(
  parameter int PTN_W = 3,
  parameter int GAP_W = 12,
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  trig_decoder_if.slave bus
);
  localparam int IDX_W = (PTN_W > 1) ? $clog2(PTN_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PTN_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_GAP} state_t;

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic [GAP_W-1:0] r_gap, w_gap_nxt;
  logic [PTN_W-1:0] r_shift, w_shift_nxt;
  logic [PTN_W:0]   w_shift_cat;
  logic             w_frame_done, w_gap_viol;

  logic [PTN_W-1:0] r_ptn;
  logic             r_ptn_valid;
  logic [CNT_W-1:0] r_trig_cnt;
  logic             r_gap_err;
  logic [CNT_W-1:0] r_err_cnt;
  logic             r_done;
  logic             r_busy;

  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [GAP_W-1:0] sat_gap(input logic [GAP_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign w_shift_cat = {r_shift, bus.trig_in};

  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_gap_nxt    = r_gap;
    w_shift_nxt  = r_shift;
    w_frame_done = 1'b0;
    w_gap_viol   = 1'b0;
    if (!bus.user_ena) begin
      w_state_nxt = S_IDLE;
      w_idx_nxt   = '0;
      w_gap_nxt   = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.trig_in) begin
            w_state_nxt = S_PAYLOAD;
            w_idx_nxt   = '0;
          end
        end
        S_PAYLOAD: begin
          w_shift_nxt = w_shift_cat[PTN_W-1:0];
          if (r_idx == LAST_IDX) begin
            w_frame_done = 1'b1;
            w_state_nxt  = S_GAP;
            w_gap_nxt    = '0;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
        S_GAP: begin
          // A header is always accepted; it is only flagged if it came too early.
          if (bus.trig_in) begin
            w_gap_viol  = (r_gap < bus.user_min_gap);
            w_state_nxt = S_PAYLOAD;
            w_idx_nxt   = '0;
          end else if (r_gap >= bus.user_min_gap) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_gap_nxt = sat_gap(r_gap);
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_gap       <= '0;
      r_shift     <= '0;
      r_ptn       <= '0;
      r_ptn_valid <= 1'b0;
      r_trig_cnt  <= '0;
      r_gap_err   <= 1'b0;
      r_err_cnt   <= '0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_gap       <= w_gap_nxt;
      r_shift     <= w_shift_nxt;
      r_ptn_valid <= w_frame_done;
      r_gap_err   <= w_gap_viol;
      r_busy      <= (w_state_nxt == S_PAYLOAD);
      r_done      <= (bus.user_ntrig != '0) && (r_trig_cnt >= bus.user_ntrig);
      if (w_frame_done) begin
        r_ptn      <= w_shift_nxt;
        r_trig_cnt <= sat_cnt(r_trig_cnt);
      end
      if (w_gap_viol) r_err_cnt <= sat_cnt(r_err_cnt);
    end
  end

  assign bus.ptn_out   = r_ptn;
  assign bus.ptn_valid = r_ptn_valid;
  assign bus.trig_cnt  = r_trig_cnt;
  assign bus.gap_err   = r_gap_err;
  assign bus.err_cnt   = r_err_cnt;
  assign bus.done      = r_done;
  assign bus.busy      = r_busy;
endmodule

// File: tb/tb_trig_decoder.sv
// Directed bench for trig_decoder: a frame-level model checked every cycle,
// plus literal expectations at the end of each scenario.
module tb_trig_decoder;
  localparam int PTN_W = 3;
  localparam int GAP_W = 12;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena, trig;
  logic [11:0] min_gap;
  logic [15:0] ntrig;
  bit         chk_en = 1'b0;
  int         checks = 0;
  int         failures = 0;

  trig_decoder_if #(.PTN_W(3), .GAP_W(12), .CNT_W(16)) bus ();
  trig_decoder_if #(.PTN_W(3), .GAP_W(12), .CNT_W(4))  bus_s ();

  assign bus.user_ena       = ena;
  assign bus.trig_in        = trig;
  assign bus.user_min_gap   = min_gap;
  assign bus.user_ntrig     = ntrig;
  assign bus_s.user_ena     = ena;
  assign bus_s.trig_in      = trig;
  assign bus_s.user_min_gap = min_gap;
  assign bus_s.user_ntrig   = 4'd0;

  trig_decoder #(.PTN_W(3), .GAP_W(12), .CNT_W(16)) dut   (.clk(clk), .rst(rst), .bus(bus));
  trig_decoder #(.PTN_W(3), .GAP_W(12), .CNT_W(4))  dut_s (.clk(clk), .rst(rst), .bus(bus_s));

  always #5 clk = ~clk;

  // Model: position inside a frame (-1 = between frames) and zeros seen since the last frame.
  int m_pos = -1, m_bits = 0, m_zeros = 0;
  bit m_in_gap = 1'b0;
  int e_ptn = 0, e_cnt = 0, e_err = 0, e_cnt_s = 0, e_err_s = 0;
  bit e_valid = 0, e_gerr = 0, e_done = 0, e_busy = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_pos = -1; m_bits = 0; m_zeros = 0; m_in_gap = 0;
      e_ptn = 0; e_cnt = 0; e_err = 0; e_cnt_s = 0; e_err_s = 0;
      e_valid = 0; e_gerr = 0; e_done = 0; e_busy = 0;
    end else begin
      e_valid = 0;
      e_gerr  = 0;
      e_done  = (ntrig != 0) && (e_cnt >= int'(ntrig));
      if (!ena) begin
        m_pos = -1; m_in_gap = 0;
      end else if (m_pos >= 0) begin
        m_bits = m_bits * 2 + int'(trig);
        m_pos++;
        if (m_pos == PTN_W) begin
          e_ptn = m_bits; e_valid = 1;
          e_cnt = (e_cnt < 65535) ? e_cnt + 1 : e_cnt;
          e_cnt_s = (e_cnt_s < 15) ? e_cnt_s + 1 : e_cnt_s;
          m_pos = -1; m_in_gap = 1; m_zeros = 0;
        end
      end else if (trig) begin
        if (m_in_gap && m_zeros < int'(min_gap)) begin
          e_gerr = 1;
          e_err = (e_err < 65535) ? e_err + 1 : e_err;
          e_err_s = (e_err_s < 15) ? e_err_s + 1 : e_err_s;
        end
        m_pos = 0; m_bits = 0; m_in_gap = 0;
      end else if (m_in_gap) begin
        if (m_zeros >= int'(min_gap)) m_in_gap = 0;
        else m_zeros++;
      end
      e_busy = (m_pos >= 0);
    end
  end

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("ptn_out",     int'(bus.ptn_out),   e_ptn);
      cmp("ptn_valid",   int'(bus.ptn_valid), int'(e_valid));
      cmp("trig_cnt",    int'(bus.trig_cnt),  e_cnt);
      cmp("gap_err",     int'(bus.gap_err),   int'(e_gerr));
      cmp("err_cnt",     int'(bus.err_cnt),   e_err);
      cmp("done",        int'(bus.done),      int'(e_done));
      cmp("busy",        int'(bus.busy),      int'(e_busy));
      cmp("s_ptn_valid", int'(bus_s.ptn_valid), int'(e_valid));
      cmp("s_trig_cnt",  int'(bus_s.trig_cnt),  e_cnt_s);
      cmp("s_err_cnt",   int'(bus_s.err_cnt),   e_err_s);
      cmp("s_done",      int'(bus_s.done),      0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_frame(input logic [2:0] p, input int zeros);
    trig = 1'b1;
    tick();
    for (int i = 2; i >= 0; i--) begin
      trig = p[i];
      tick();
    end
    trig = 1'b0;
    repeat (zeros) tick();
  endtask

  logic [2:0] pats [4] = '{3'b000, 3'b111, 3'b010, 3'b100};
  logic [2:0] pv;

  initial begin
    rst = 1'b1; ena = 1'b0; trig = 1'b0; min_gap = 12'd5; ntrig = 16'd0;
    tick(); tick();
    chk_en = 1'b1;
    cmp("rst_ptn_out", int'(bus.ptn_out), 0);
    cmp("rst_trig_cnt", int'(bus.trig_cnt), 0);
    cmp("rst_busy", int'(bus.busy), 0);
    rst = 1'b0; ena = 1'b1;
    repeat (6) tick();

    // single frame 1,1,0,1
    trig = 1'b1; tick();
    trig = 1'b1; tick();
    trig = 1'b0; tick();
    trig = 1'b1; tick();
    trig = 1'b0;
    cmp("single_valid", int'(bus.ptn_valid), 1);
    cmp("single_ptn", int'(bus.ptn_out), 5);
    cmp("single_cnt", int'(bus.trig_cnt), 1);
    repeat (10) tick();
    cmp("single_err", int'(bus.err_cnt), 0);

    // generator loop of four frames
    rst = 1'b1; tick(); rst = 1'b0;
    min_gap = 12'd8; ntrig = 16'd4;
    for (int i = 0; i < 4; i++) send_frame(pats[i], 8);
    cmp("loop_cnt", int'(bus.trig_cnt), 4);
    cmp("loop_done", int'(bus.done), 1);
    cmp("loop_err", int'(bus.err_cnt), 0);
    cmp("loop_ptn", int'(bus.ptn_out), 4);

    // gap violation: header after only 3 zeros
    send_frame(3'b011, 3);
    send_frame(3'b110, 8);
    cmp("viol_err", int'(bus.err_cnt), 1);
    cmp("viol_cnt", int'(bus.trig_cnt), 6);
    cmp("viol_ptn", int'(bus.ptn_out), 6);

    // boundary: exactly min_gap zeros, then back-to-back with min_gap=0
    send_frame(3'b001, 8);
    cmp("bound_err", int'(bus.err_cnt), 1);
    min_gap = 12'd0;
    send_frame(3'b101, 0);
    send_frame(3'b011, 0);
    send_frame(3'b010, 2);
    cmp("b2b_err", int'(bus.err_cnt), 1);
    cmp("b2b_cnt", int'(bus.trig_cnt), 10);
    cmp("b2b_ptn", int'(bus.ptn_out), 2);

    // abort via user_ena on the completing bit
    min_gap = 12'd4;
    trig = 1'b1; tick();
    trig = 1'b1; tick();
    trig = 1'b0; tick();
    ena = 1'b0; trig = 1'b1; tick();
    ena = 1'b1; trig = 1'b0;
    repeat (6) tick();
    cmp("abort_cnt", int'(bus.trig_cnt), 10);
    cmp("abort_ptn", int'(bus.ptn_out), 2);

    // reset mid-payload
    trig = 1'b1; tick();
    trig = 1'b0; tick();
    rst = 1'b1; tick();
    rst = 1'b0;
    cmp("rstmid_ptn", int'(bus.ptn_out), 0);
    cmp("rstmid_cnt", int'(bus.trig_cnt), 0);
    cmp("rstmid_err", int'(bus.err_cnt), 0);
    cmp("rstmid_busy", int'(bus.busy), 0);
    send_frame(3'b111, 4);
    cmp("after_rst_cnt", int'(bus.trig_cnt), 1);
    cmp("after_rst_ptn", int'(bus.ptn_out), 7);

    // saturation of the 4-bit counter, done disabled
    ntrig = 16'd0;
    for (int i = 0; i < 17; i++) begin
      pv = 3'(i);
      send_frame(pv, 4);
    end
    cmp("sat_s_cnt", int'(bus_s.trig_cnt), 15);
    cmp("sat_cnt", int'(bus.trig_cnt), 18);
    cmp("sat_done", int'(bus.done), 0);
    repeat (3) tick();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
